switch_debouncer: RTL and testbench



---
 rtl/debounce_bit.sv | 57 +++++
 rtl/switch_debouncer.sv | 33 +++
 tb/tb_switch_debouncer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/debounce_bit.sv
// One switch bit: two-flop synchroniser, stability counter, debounced value
// and a sticky change flag that a clear pulse cannot override on the same edge.
module debounce_bit #(
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw_i,
  input  logic clear_i,
  output logic deb_o,
  output logic chg_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             deb_q, deb_d;
  logic             chg_q, chg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      deb_q <= 1'b0;
      chg_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= raw_i;
      s2_q  <= s1_q;
      deb_q <= deb_d;
      chg_q <= chg_d;
      cnt_q <= cnt_d;
    end
  end

  // Any sample agreeing with the debounced value restarts the stability window.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    chg_d = clear_i ? 1'b0 : chg_q;
    if (s2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      deb_d = s2_q;
      cnt_d = '0;
      chg_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign deb_o = deb_q;
  assign chg_o = chg_q;

endmodule

// File: rtl/switch_debouncer.sv
// Synchronises and debounces the board slide switches for the memory-mapped
// switch read path, with sticky per-bit change flags for software polling.
module switch_debouncer #(
  parameter int WIDTH         = 16,
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] switches_raw,
  input  logic             clear_changes,
  output logic [WIDTH-1:0] switches,
  output logic [WIDTH-1:0] changed,
  output logic             any_change
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W)
    ) u_bit (
      .clock   (clock),
      .reset_n (reset_n),
      .raw_i   (switches_raw[g]),
      .clear_i (clear_changes),
      .deb_o   (switches[g]),
      .chg_o   (changed[g])
    );
  end

  assign any_change = |changed;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer with a short stability window; expected values
// come from a window-over-history model of the synchronised switch samples.
module tb_switch_debouncer;
  localparam int W = 16;
  localparam int S = 4;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] switches_raw = '0;
  logic         clear_changes = 1'b0;
  logic [W-1:0] switches;
  logic [W-1:0] changed;
  logic         any_change;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] hist[$];
  logic [W-1:0] exp_sw = '0;
  logic [W-1:0] exp_chg = '0;

  switch_debouncer #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .switches_raw  (switches_raw),
    .clear_changes (clear_changes),
    .switches      (switches),
    .changed       (changed),
    .any_change    (any_change)
  );

  always #5 clock = ~clock;

  // The bit updates at edge t when the raw values driven before edges
  // t-S-1 .. t-2 (what the synchroniser delivers) all differ from it.
  task automatic step(input logic [W-1:0] raw, input logic clr);
    logic [W-1:0] nsw;
    logic         diff_all;
    logic         smp;
    int           t;
    switches_raw  = raw;
    clear_changes = clr;
    @(posedge clock);
    hist.push_back(raw);
    t   = hist.size();
    nsw = exp_sw;
    for (int i = 0; i < W; i++) begin
      diff_all = 1'b1;
      for (int k = t - S - 1; k <= t - 2; k++) begin
        smp = (k >= 1) ? hist[k-1][i] : 1'b0;
        if (smp == exp_sw[i]) diff_all = 1'b0;
      end
      if (diff_all) nsw[i] = ~exp_sw[i];
    end
    exp_chg = (clr ? '0 : exp_chg) | (nsw ^ exp_sw);
    exp_sw  = nsw;
    #1;
    clear_changes = 1'b0;
  endtask

  task automatic apply_reset(input logic [W-1:0] raw);
    reset_n      = 1'b0;
    switches_raw = raw;
    hist.delete();
    exp_sw  = '0;
    exp_chg = '0;
    #2;
    checks++;
    if (switches !== '0 || changed !== '0 || any_change !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: switches=%h changed=%h any=%b expected 0 0 0",
               switches, changed, any_change);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset(16'hFFFF);
    for (int e = 1; e <= 6; e++) begin
      step(16'hFFFF, 1'b0);
      checks++;
      if (switches !== exp_sw || changed !== exp_chg || any_change !== (|exp_chg)) begin
        errors++;
        $display("FAIL reset_release edge %0d: sw=%h chg=%h any=%b exp %h %h %b",
                 e, switches, changed, any_change, exp_sw, exp_chg, |exp_chg);
      end
      checks++;
      if (switches !== ((e < 6) ? 16'h0000 : 16'hFFFF)) begin
        errors++;
        $display("FAIL reset_latency edge %0d: sw=%h", e, switches);
      end
    end
    checks++;
    if (changed !== 16'hFFFF || any_change !== 1'b1) begin
      errors++;
      $display("FAIL reset_changed: chg=%h any=%b expected ffff 1", changed, any_change);
    end
  endtask

  task automatic test_single_bit();
    apply_reset('0);
    for (int e = 1; e <= 7; e++) begin
      step(16'h0008, 1'b0);
      checks++;
      if (switches !== exp_sw || changed !== exp_chg || switches[3] !== (e >= 6)) begin
        errors++;
        $display("FAIL single_bit edge %0d: sw=%h chg=%h exp %h %h",
                 e, switches, changed, exp_sw, exp_chg);
      end
    end
    checks++;
    if (changed !== 16'h0008 || any_change !== 1'b1) begin
      errors++;
      $display("FAIL single_bit_flag: chg=%h any=%b expected 0008 1", changed, any_change);
    end
  endtask

  task automatic test_glitch();
    apply_reset('0);
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 6; c++) begin
        step((c < 3) ? 16'h0001 : 16'h0000, 1'b0);
        checks++;
        if (switches !== exp_sw || changed !== exp_chg || switches[0] !== 1'b0) begin
          errors++;
          $display("FAIL glitch r%0d c%0d: sw=%h chg=%h exp %h %h",
                   r, c, switches, changed, exp_sw, exp_chg);
        end
      end
    end
    checks++;
    if (changed[0] !== 1'b0 || any_change !== 1'b0) begin
      errors++;
      $display("FAIL glitch_flag: chg=%h any=%b expected 0000 0", changed, any_change);
    end
  endtask

  task automatic test_clear_collision();
    apply_reset('0);
    for (int e = 1; e <= 6; e++) begin
      step(16'h0020, e == 6);
    end
    checks++;
    if (switches !== 16'h0020 || changed !== 16'h0020 || changed !== exp_chg) begin
      errors++;
      $display("FAIL clear_collision: sw=%h chg=%h expected 0020 0020", switches, changed);
    end
    step(16'h0020, 1'b1);
    checks++;
    if (changed !== 16'h0000 || any_change !== 1'b0 || changed !== exp_chg) begin
      errors++;
      $display("FAIL clear_after: chg=%h any=%b expected 0000 0", changed, any_change);
    end
  endtask

  task automatic test_reset_midcount();
    apply_reset('0);
    for (int e = 1; e <= 3; e++) step(16'hA5A5, 1'b0);
    apply_reset(16'hA5A5);
    for (int e = 1; e <= 6; e++) begin
      step(16'hA5A5, 1'b0);
      checks++;
      if (switches !== exp_sw || changed !== exp_chg ||
          switches !== ((e < 6) ? 16'h0000 : 16'hA5A5)) begin
        errors++;
        $display("FAIL reset_midcount edge %0d: sw=%h chg=%h exp %h %h",
                 e, switches, changed, exp_sw, exp_chg);
      end
    end
  endtask

  task automatic test_independent_bits();
    apply_reset('0);
    for (int e = 1; e <= 9; e++) begin
      step((e >= 3) ? 16'h8001 : 16'h8000, 1'b0);
      checks++;
      if (switches !== exp_sw || changed !== exp_chg ||
          switches[15] !== (e >= 6) || switches[0] !== (e >= 8)) begin
        errors++;
        $display("FAIL independent edge %0d: sw=%h chg=%h exp %h %h",
                 e, switches, changed, exp_sw, exp_chg);
      end
    end
    checks++;
    if (changed !== 16'h8001) begin
      errors++;
      $display("FAIL independent_flag: chg=%h expected 8001", changed);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] raw;
    logic [W-1:0] flip;
    apply_reset('0);
    raw = '0;
    for (int n = 0; n < 400; n++) begin
      flip = '0;
      for (int i = 0; i < W; i++) flip[i] = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 1) == 0) raw = raw ^ flip;
      step(raw, $urandom_range(0, 9) == 0);
      checks++;
      if (switches !== exp_sw || changed !== exp_chg || any_change !== (|exp_chg)) begin
        errors++;
        $display("FAIL random step %0d: sw=%h chg=%h any=%b exp %h %h %b",
                 n, switches, changed, any_change, exp_sw, exp_chg, |exp_chg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_bit();
    test_glitch();
    test_clear_collision();
    test_reset_midcount();
    test_independent_bits();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
